apb_bridge_controller: RTL
==========================

# apb_bridge_controller

Sequencing FSM for the AHB-to-APB bridge. It accepts AHB-Lite transfers, decodes one of three APB slaves and runs the two-cycle APB SETUP/ENABLE protocol. It stretches AHB data phases through hready_out, and returns an AHB ERROR response for unmapped addresses. It sits between the AHB slave port and the APB interface stage, and drives that stage's penable, pwrite, pselx, paddr and pwdata inputs.

## Interface
- ADDR_W, 32, address width
- DATA_W, 32, data width
- hclk  in  1  bridge clock; all state changes on rising edge
- hresetn  in  1  asynchronous, active-low reset
- hsel  in  1  bridge selected by AHB decoder
- htrans  in  2  AHB transfer type: 0 IDLE, 1 BUSY, 2 NONSEQ, 3 SEQ
- hwrite  in  1  AHB direction, 1 = write
- haddr  in  ADDR_W  AHB address (address phase)
- hwdata  in  DATA_W  AHB write data (data phase)
- prdata  in  DATA_W  read data from APB slaves
- hready_out  out  1  AHB ready; 0 stretches the current data phase
- hresp  out  1  AHB response, 1 = ERROR
- hrdata  out  DATA_W  AHB read data
- penable  out  1  APB enable
- pwrite  out  1  APB direction
- pselx  out  3  one-hot APB slave select
- paddr  out  ADDR_W  APB address
- pwdata  out  DATA_W  APB write data

## Operation
- Accept condition: valid = hsel & htrans[1] & hready_out.
  - BUSY and IDLE transfers are never accepted.
- On accept, register the following: haddr into addr_r, hwrite into write_r, and the decode result into sel_r.
- Decode on haddr[31:26]:
  - 0x20 (0x8000_0000–0x83FF_FFFF) -> 3'b001
  - 0x21 -> 3'b010
  - 0x22 -> 3'b100
  - anything else -> unmapped.
- States and transitions:
  - IDLE: if not valid, stay in IDLE. If valid and unmapped, go to ERR1. If valid and write, go to WDATA. If valid and read, go to SETUP.
  - WDATA: capture hwdata into wdata_r, then go to SETUP.
  - SETUP: go to ENABLE.
  - ENABLE: re-evaluate valid, since this cycle completes the data phase, using the same branches as IDLE. If not valid, go to IDLE.
  - ERR1: go to ERR2.
  - ERR2: re-evaluate valid using the same branches as IDLE.
- Outputs are decoded from state plus registers only; none is combinational from AHB inputs.
  - hready_out = 1 in IDLE, ENABLE and ERR2; 0 in WDATA, SETUP and ERR1.
  - hresp = 1 in ERR1 and ERR2; otherwise 0.
  - pselx = sel_r in SETUP and ENABLE; otherwise 3'b000.
  - penable = 1 only in ENABLE.
  - pwrite = write_r in SETUP and ENABLE; otherwise 0.
  - paddr = addr_r in SETUP and ENABLE.
  - pwdata = wdata_r in SETUP and ENABLE.
  - hrdata = prdata in ENABLE when write_r = 0; otherwise 0.
- Unmapped transfers never assert pselx or penable. The ERROR response is the standard two cycles (hresp=1/hready=0, then hresp=1/hready=1).
- Reads capture no data; prdata is passed to hrdata only in ENABLE.

## Timing
- Reset (hresetn low, asynchronous) sets:
  - state = IDLE
  - addr_r, wdata_r, sel_r, write_r = 0
  - hready_out = 1, hresp = 0, hrdata = 0, penable = 0, pwrite = 0, pselx = 0, paddr = 0, pwdata = 0.
- Reset asserted mid-transfer aborts it immediately, with no completion on either bus. Operation resumes on the first hclk edge after release.
- Read, address accepted at edge N:
  - SETUP during cycle N+1
  - ENABLE during cycle N+2, with hrdata valid and hready_out=1
  - Total: 2 data-phase cycles, 1 wait state.
- Write, address accepted at edge N:
  - WDATA during cycle N+1
  - SETUP during cycle N+2
  - ENABLE during cycle N+3, with hready_out=1
  - Total: 2 wait states.
- Back-to-back transfers: a transfer presented during ENABLE or ERR2 is accepted there, with no IDLE bubble.
  - Read-read sustains one transfer per 2 cycles.
  - Write-write sustains one transfer per 3 cycles.
- The master holds haddr and hwdata stable while hready_out=0; the block relies on this.
- A transfer presented while hready_out=0 is ignored until the next ready cycle, per AHB.
- paddr, pwdata and pwrite are stable across SETUP and ENABLE.
- pselx is asserted one cycle before penable and deasserts with it.

## Test plan
- Reset: hold hresetn=0 with random inputs -> hready_out=1, all other outputs 0. Release, then idle for 3 cycles -> outputs unchanged.
- Single write: hsel=1, htrans=2, hwrite=1, haddr=0x8000_0010, then hwdata=0xDEAD_BEEF in the next cycle. Required response:
  - pselx=001 for 2 cycles
  - penable=1 in the second of them
  - paddr=0x8000_0010, pwdata=0xDEAD_BEEF, pwrite=1
  - hready_out sequence 1,0,0,1.
- Single read: haddr=0x8400_0004, hwrite=0, prdata=0x0000_0019. Required response:
  - pselx=010, pwrite=0
  - hrdata=0x19 in the ENABLE cycle
  - hready_out sequence 1,0,1.
- Back-to-back: read 0x8800_0000, then write 0x8000_0008 presented during the read's ENABLE. Required response:
  - pselx goes 100,100,000(WDATA),001,001
  - no IDLE state between the two transfers.
- Unmapped: haddr=0x9000_0000 -> hresp=1/hready_out=0, then hresp=1/hready_out=1. pselx stays 0 throughout.
- Abort: drop hresetn during SETUP of a write -> pselx, penable and pwrite go to 0 without waiting for hclk. The next transfer after release completes normally.

Source files
------------

// File: rtl/apb_bridge_controller.sv
// AHB-Lite to APB sequencing FSM: decodes three APB slaves, runs SETUP/ENABLE,
// stretches AHB data phases via hready_out and answers unmapped addresses with a two-cycle ERROR.
module apb_bridge_controller #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              hclk,
  input  logic              hresetn,
  input  logic              hsel,
  input  logic [1:0]        htrans,
  input  logic              hwrite,
  input  logic [ADDR_W-1:0] haddr,
  input  logic [DATA_W-1:0] hwdata,
  input  logic [DATA_W-1:0] prdata,
  output logic              hready_out,
  output logic              hresp,
  output logic [DATA_W-1:0] hrdata,
  output logic              penable,
  output logic              pwrite,
  output logic [2:0]        pselx,
  output logic [ADDR_W-1:0] paddr,
  output logic [DATA_W-1:0] pwdata
);

  typedef enum logic [2:0] {
    S_IDLE, S_WDATA, S_SETUP, S_ENABLE, S_ERR1, S_ERR2
  } state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [2:0]          sel_q, sel_d;
  logic                write_q, write_d;
  logic                hready_q, hresp_q, penable_q, pwrite_q;
  logic [2:0]          pselx_q;
  logic                valid;
  logic [2:0]          dec_sel;
  logic                apb_phase_d;
  logic                unused_htrans0;

  assign unused_htrans0 = htrans[0];

  // Only NONSEQ/SEQ while the previous data phase is completing are accepted.
  assign valid = hsel & htrans[1] & hready_q;

  always_comb begin
    dec_sel = 3'b000;
    case (haddr[ADDR_W-1 -: 6])
      6'h20:   dec_sel = 3'b001;
      6'h21:   dec_sel = 3'b010;
      6'h22:   dec_sel = 3'b100;
      default: dec_sel = 3'b000;
    endcase
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    write_d = write_q;
    sel_d   = sel_q;
    wdata_d = wdata_q;
    case (state_q)
      S_IDLE, S_ENABLE, S_ERR2: begin
        if (valid) begin
          addr_d  = haddr;
          write_d = hwrite;
          sel_d   = dec_sel;
          if (dec_sel == 3'b000) state_d = S_ERR1;
          else if (hwrite)       state_d = S_WDATA;
          else                   state_d = S_SETUP;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_WDATA: begin
        wdata_d = hwdata;
        state_d = S_SETUP;
      end
      S_SETUP: state_d = S_ENABLE;
      S_ERR1:  state_d = S_ERR2;
      default: state_d = S_IDLE;
    endcase
  end

  assign apb_phase_d = (state_d == S_SETUP) || (state_d == S_ENABLE);

  // Outputs are registered from the next state so they are glitch-free and
  // never combinational from the AHB side.
  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      state_q   <= S_IDLE;
      addr_q    <= '0;
      wdata_q   <= '0;
      sel_q     <= 3'b000;
      write_q   <= 1'b0;
      hready_q  <= 1'b1;
      hresp_q   <= 1'b0;
      penable_q <= 1'b0;
      pwrite_q  <= 1'b0;
      pselx_q   <= 3'b000;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      sel_q     <= sel_d;
      write_q   <= write_d;
      hready_q  <= (state_d == S_IDLE) || (state_d == S_ENABLE) || (state_d == S_ERR2);
      hresp_q   <= (state_d == S_ERR1) || (state_d == S_ERR2);
      penable_q <= (state_d == S_ENABLE);
      pwrite_q  <= apb_phase_d & write_d;
      pselx_q   <= apb_phase_d ? sel_d : 3'b000;
    end
  end

  assign hready_out = hready_q;
  assign hresp      = hresp_q;
  assign penable    = penable_q;
  assign pwrite     = pwrite_q;
  assign pselx      = pselx_q;
  assign paddr      = addr_q;
  assign pwdata     = wdata_q;
  assign hrdata     = (penable_q && !pwrite_q) ? prdata : '0;

endmodule
